// File: rtl/instr_cache_burst_if.sv
// Fetch-side and refill-side signals of the instruction cache, bundled.
// slave: the cache itself; master: the CPU fetch unit plus refill arbiter.
interface instr_cache_burst_if;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic        inst_sram_stall;
    logic        flush;
    logic        inst_cache_req;
    logic [31:0] inst_cache_addr;
    logic        inst_cache_ack;
    logic [31:0] inst_cache_rdata;
    logic        inst_cache_dok;

    modport slave (
        input  inst_sram_en, inst_sram_addr, flush,
        input  inst_cache_ack, inst_cache_rdata, inst_cache_dok,
        output inst_sram_rdata, inst_sram_stall,
        output inst_cache_req, inst_cache_addr
    );

    modport master (
        output inst_sram_en, inst_sram_addr, flush,
        output inst_cache_ack, inst_cache_rdata, inst_cache_dok,
        input  inst_sram_rdata, inst_sram_stall,
        input  inst_cache_req, inst_cache_addr
    );
endinterface

// File: rtl/instr_cache_burst.sv
// Direct-mapped instruction cache with combinational hit lookup and
// word-0-first burst refill; a flush sweeps the valid bits one set per cycle.
module instr_cache_burst #(
    parameter int INDEX_BITS = 7,
    parameter int WORD_BITS  = 3
) (
    input  logic                clk,
    input  logic                rst,
    instr_cache_burst_if.slave  bus
);
    localparam int SETS     = 1 << INDEX_BITS;
    localparam int WORDS    = 1 << WORD_BITS;
    localparam int OFF_BITS = WORD_BITS + 2;
    localparam int TAG_BITS = 32 - INDEX_BITS - WORD_BITS - 2;

    typedef enum logic [1:0] {IDLE, REQ, REFILL, FLUSH} state_t;

    state_t                 state_q, state_d;
    logic [SETS-1:0]        valid_q;
    logic [TAG_BITS-1:0]    tag_q  [SETS];
    logic [31:0]            data_q [SETS][WORDS];
    logic [WORD_BITS-1:0]   beat_q;
    logic [INDEX_BITS-1:0]  flush_idx_q;
    logic                   flush_pend_q;
    logic [31:0]            line_addr_q;

    logic [TAG_BITS-1:0]    req_tag, fill_tag;
    logic [INDEX_BITS-1:0]  req_idx, fill_idx;
    logic [WORD_BITS-1:0]   req_word;
    logic                   hit, miss, last_beat;
    logic                   unused_addr_bits;

    assign req_tag  = bus.inst_sram_addr[31 -: TAG_BITS];
    assign req_idx  = bus.inst_sram_addr[OFF_BITS +: INDEX_BITS];
    assign req_word = bus.inst_sram_addr[2 +: WORD_BITS];
    assign fill_tag = line_addr_q[31 -: TAG_BITS];
    assign fill_idx = line_addr_q[OFF_BITS +: INDEX_BITS];
    assign unused_addr_bits = ^bus.inst_sram_addr[1:0];

    assign hit       = (state_q == IDLE) && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign miss      = bus.inst_sram_en && !hit;
    assign last_beat = bus.inst_cache_dok && (beat_q == WORD_BITS'(WORDS - 1));

    assign bus.inst_sram_rdata = hit ? data_q[req_idx][req_word] : 32'b0;
    assign bus.inst_sram_stall = miss;
    assign bus.inst_cache_req  = (state_q == REQ);
    assign bus.inst_cache_addr = line_addr_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.flush)           state_d = FLUSH;
                     else if (miss)           state_d = REQ;
            REQ:     if (bus.inst_cache_ack)  state_d = REFILL;
            REFILL:  if (last_beat)           state_d = (flush_pend_q || bus.flush) ? FLUSH : IDLE;
            FLUSH:   if (flush_idx_q == '1)   state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= '0;
            beat_q       <= '0;
            flush_idx_q  <= '0;
            flush_pend_q <= 1'b0;
            line_addr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!bus.flush && miss)
                        line_addr_q <= {bus.inst_sram_addr[31:OFF_BITS], {OFF_BITS{1'b0}}};
                end
                REQ: begin
                    if (bus.flush)          flush_pend_q <= 1'b1;
                    if (bus.inst_cache_ack) beat_q <= '0;
                end
                REFILL: begin
                    if (bus.flush) flush_pend_q <= 1'b1;
                    if (bus.inst_cache_dok) begin
                        beat_q <= beat_q + WORD_BITS'(1);
                        // a half-written line must never hit
                        if (beat_q == '0) valid_q[fill_idx] <= 1'b0;
                        if (last_beat) begin
                            valid_q[fill_idx] <= 1'b1;
                            flush_pend_q      <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    valid_q[flush_idx_q] <= 1'b0;
                    flush_idx_q          <= flush_idx_q + INDEX_BITS'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state_q == REFILL && bus.inst_cache_dok) begin
            data_q[fill_idx][beat_q] <= bus.inst_cache_rdata;
            if (last_beat) tag_q[fill_idx] <= fill_tag;
        end
    end
endmodule

// File: tb/tb_instr_cache_burst.sv
module tb_instr_cache_burst;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] base;
    } burst_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   beat_no = 0;

    logic [31:0] exp_fetch[$];
    burst_t      exp_req[$];

    instr_cache_burst_if bus();

    instr_cache_burst dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    // scoreboard monitor: every satisfied fetch consumes one expected word
    always @(negedge clk) begin
        if (bus.inst_sram_en && !bus.inst_sram_stall && !rst) begin
            if (exp_fetch.size() == 0) fail_now("unexpected_fetch_data");
            else check("rdata", bus.inst_sram_rdata, exp_fetch.pop_front());
        end
    end

    // refill arbiter/memory: checks burst address, acks, streams 8 beats
    task automatic serve_burst();
        burst_t b;
        if (exp_req.size() == 0) begin
            fail_now("extra_burst_req");
            b.addr = bus.inst_cache_addr;
            b.base = 32'hDEAD_0000;
        end else begin
            b = exp_req.pop_front();
            check("burst_addr", bus.inst_cache_addr, b.addr);
        end
        bus.inst_cache_ack = 1'b1;
        beat_no = 0;
        @(negedge clk);
        bus.inst_cache_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.inst_cache_dok   = 1'b1;
            bus.inst_cache_rdata = b.base + i;
            beat_no = i + 1;
            @(negedge clk);
        end
        bus.inst_cache_dok   = 1'b0;
        bus.inst_cache_rdata = 32'h0;
    endtask

    initial begin
        bus.inst_cache_ack   = 1'b0;
        bus.inst_cache_dok   = 1'b0;
        bus.inst_cache_rdata = 32'h0;
        @(negedge clk);
        forever begin
            if (bus.inst_cache_req && !rst) serve_burst();
            else @(negedge clk);
        end
    end

    task automatic fetch(input logic [31:0] a, input logic [31:0] exp, input int exp_stalls);
        int n;
        @(posedge clk);
        #1;
        exp_fetch.push_back(exp);
        bus.inst_sram_en   = 1'b1;
        bus.inst_sram_addr = a;
        n = 0;
        forever begin
            @(negedge clk);
            if (!bus.inst_sram_stall) break;
            n++;
            if (n > 400) begin
                fail_now("fetch_timeout");
                break;
            end
        end
        if (exp_stalls >= 0) check("stall_cycles", n, exp_stalls);
        @(posedge clk);
        #1;
        bus.inst_sram_en = 1'b0;
    endtask

    task automatic wait_beat(input int b);
        int k;
        k = 0;
        while (beat_no != b && k < 2000) begin
            @(beat_no or negedge clk);
            k++;
        end
        if (k >= 2000) fail_now("beat_wait_timeout");
    endtask

    task automatic pulse_flush();
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.inst_sram_en   = 1'b1;
        bus.inst_sram_addr = 32'h0000_1040;
        bus.flush          = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall_en1", bus.inst_sram_stall, 1'b1);
        check("rst_rdata", bus.inst_sram_rdata, 32'h0);
        check("rst_req", bus.inst_cache_req, 1'b0);
        check("rst_cache_addr", bus.inst_cache_addr, 32'h0);
        bus.inst_sram_en = 1'b0;
        #1;
        check("rst_stall_en0", bus.inst_sram_stall, 1'b0);
        rst = 1'b0;

        // cold miss, hits in the same line, conflict eviction
        exp_req.push_back('{32'h0000_1040, 32'hA0});
        fetch(32'h0000_1040, 32'hA0, 10);
        fetch(32'h0000_105C, 32'hA7, 0);
        fetch(32'h0000_1048, 32'hA2, 0);
        exp_req.push_back('{32'h0000_2040, 32'hB0});
        fetch(32'h0000_2040, 32'hB0, 10);
        exp_req.push_back('{32'h0000_1040, 32'hC0});
        fetch(32'h0000_1040, 32'hC0, 10);
        exp_req.push_back('{32'h0000_3080, 32'hD0});
        fetch(32'h0000_308C, 32'hD3, 10);
        fetch(32'h0000_1044, 32'hC1, 0);

        // flush at beat 3 of a refill, second flush absorbed during the sweep
        exp_req.push_back('{32'h0000_4100, 32'hE0});
        exp_req.push_back('{32'h0000_4100, 32'hF0});
        fork
            fetch(32'h0000_4100, 32'hF0, 148);
            begin
                wait_beat(3);
                pulse_flush();
                wait_beat(8);
                repeat (40) @(negedge clk);
                pulse_flush();
            end
        join
        exp_req.push_back('{32'h0000_1040, 32'h10});
        fetch(32'h0000_1040, 32'h10, 10);

        // en dropped and addr changed mid-refill: latched line still fills
        exp_req.push_back('{32'h0000_5200, 32'h50});
        @(posedge clk);
        #1;
        bus.inst_sram_en   = 1'b1;
        bus.inst_sram_addr = 32'h0000_5200;
        wait_beat(2);
        bus.inst_sram_en   = 1'b0;
        bus.inst_sram_addr = 32'h9999_0000;
        wait_beat(8);
        repeat (3) @(negedge clk);
        check("no_req_after_drop", bus.inst_cache_req, 1'b0);
        fetch(32'h0000_521C, 32'h57, 0);

        // reset mid-refill: burst aborted, stray beats ignored
        exp_req.push_back('{32'h0000_6300, 32'h60});
        @(posedge clk);
        #1;
        bus.inst_sram_en   = 1'b1;
        bus.inst_sram_addr = 32'h0000_6300;
        wait_beat(4);
        bus.inst_sram_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_req", bus.inst_cache_req, 1'b0);
        check("rst_mid_cache_addr", bus.inst_cache_addr, 32'h0);
        rst = 1'b0;
        wait_beat(8);
        repeat (3) @(negedge clk);
        check("stray_beats_no_req", bus.inst_cache_req, 1'b0);
        exp_req.push_back('{32'h0000_5200, 32'h70});
        fetch(32'h0000_521C, 32'h77, 10);
        exp_req.push_back('{32'h0000_6300, 32'h80});
        fetch(32'h0000_6300, 32'h80, 10);

        repeat (5) @(negedge clk);
        check("pending_bursts", exp_req.size(), 0);
        check("pending_fetches", exp_fetch.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_cache_burst.md
INSTR_CACHE_BURST -- requirements
Module: instr_cache_burst

Interface
REQ-001 Parameter INDEX_BITS, default 7: number of sets = 2^INDEX_BITS.
REQ-002 Parameter WORD_BITS, default 3: words per line = 2^WORD_BITS; line bytes = 4*2^WORD_BITS.
REQ-003 Derived TAG_BITS = 32-INDEX_BITS-WORD_BITS-2; address split tag[31:32-TAG_BITS], index, word offset, byte offset[1:0].
REQ-004 clk  in  1  sole clock, all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 inst_sram_en  in  1  fetch request valid this cycle.
REQ-007 inst_sram_addr  in  32  fetch byte address, word aligned.
REQ-008 inst_sram_rdata  out  32  fetched instruction, valid when en=1 and stall=0.
REQ-009 inst_sram_stall  out  1  fetch not satisfied this cycle; CPU holds addr/en.
REQ-010 flush  in  1  one-cycle pulse: invalidate entire cache.
REQ-011 inst_cache_req  out  1  burst read request to arbiter.
REQ-012 inst_cache_addr  out  32  line-aligned burst start address (low WORD_BITS+2 bits zero).
REQ-013 inst_cache_ack  in  1  arbiter accepted request this cycle.
REQ-014 inst_cache_rdata  in  32  refill beat data.
REQ-015 inst_cache_dok  in  1  refill beat valid; beats arrive word 0 upward, exactly 2^WORD_BITS per burst.

Function
REQ-016 Storage: per set one valid bit, TAG_BITS tag, 2^WORD_BITS data words; direct mapped; asynchronous read.
REQ-017 Hit = state IDLE and valid[index] and tag[index]==addr tag; evaluated combinationally same cycle.
REQ-018 inst_sram_rdata = data[index][word offset] on hit; 32'b0 otherwise.
REQ-019 inst_sram_stall = inst_sram_en and not hit; stall=0 whenever en=0.
REQ-020 FSM states: IDLE, REQ, REFILL, FLUSH.
REQ-021 IDLE: en=1 and miss -> latch line address, go REQ; flush=1 has priority over miss -> go FLUSH.
REQ-022 REQ: inst_cache_req=1, inst_cache_addr=latched line address; ack=1 -> REFILL with beat counter 0; req drops the cycle after ack.
REQ-023 REFILL: each dok beat writes rdata into data[latched index][counter], counter +1.
REQ-024 On beat counter = 2^WORD_BITS-1 with dok: write tag, set valid, go IDLE; counter wraps to 0.
REQ-025 Valid bit cleared at first beat of refill so a partially refilled line never hits.
REQ-026 Miss-to-hit latency: ack cycle + 2^WORD_BITS beats + 1 cycle (re-lookup in IDLE).
REQ-027 Refill completes regardless of en or addr changes; re-lookup uses current addr.
REQ-028 dok outside REFILL and ack outside REQ are ignored.
REQ-029 flush during REQ or REFILL: recorded in pending bit; FLUSH entered on refill completion instead of IDLE; refilled line is then invalidated.
REQ-030 FLUSH: clears valid of one set per cycle, index 0 upward, 2^INDEX_BITS cycles, then IDLE; stall=1 for en=1 throughout.
REQ-031 flush arriving during FLUSH restarts nothing and is absorbed.
REQ-032 Tag/data arrays need no reset; only valid bits, FSM, counters, pending bit are reset.

Reset
REQ-033 rst=1 at a clock edge: state IDLE, all valid bits 0, beat counter 0, flush-pending 0, inst_cache_req 0, inst_cache_addr 0.
REQ-034 Outputs during/after reset: inst_sram_stall = inst_sram_en, inst_sram_rdata 0.
REQ-035 rst mid-REQ or mid-REFILL aborts the burst; subsequent stray dok beats are ignored (REQ-028).

Verification (defaults: 128 sets, 8 words/line)
REQ-036 After reset, en=1 addr=0x0000_1040 -> stall=1; req=1 addr=0x0000_1040; ack; 8 beats 0xA0..0xA7 -> stall=0 one cycle after last beat, rdata=0xA0.
REQ-037 Following hit addr=0x0000_105C -> stall=0 same cycle, rdata=0xA7; no req.
REQ-038 Conflict addr=0x0000_2040 (same index, new tag) -> miss, refill, then 0x0000_1040 misses again.
REQ-039 flush pulse mid-REFILL at beat 3 -> burst completes, FLUSH runs 128 cycles, then 0x0000_1040 misses.
REQ-040 rst asserted at beat 4 of refill -> req=0, valid all 0; remaining 4 dok beats change nothing; next fetch of that line misses.
REQ-041 en dropped and addr changed during refill -> refill completes to latched line; no extra req issued.
